// File: rtl/ps2_kbd_ctrl.sv
// PS/2 keyboard controller: RX scan-code FIFO plus host-to-device command sequencer.
// Optional resend-on-failure behaviour is enabled by defining PS2K_CMD_RETRY_EN.
module ps2_kbd_ctrl #(
  parameter int FIFO_AW         = 4,
  parameter int RESP_TIMEOUT_US = 20000,
  parameter int MAX_RETRY       = 3
) (
  input  logic               clk6x,
  input  logic               resetn,
  input  logic               ck1us,
  output logic [7:0]         kbd_head_o,
  input  logic               kbd_deq_i,
  output logic [FIFO_AW:0]   kbd_count_o,
  output logic               kbd_ovf_o,
  input  logic [7:0]         cmd_i,
  input  logic               cmd_v_i,
  output logic               cmd_busy_o,
  output logic [7:0]         status_o,
  output logic [7:0]         ps2_cmd_o,
  output logic               ps2_cmd_v_o,
  input  logic               ps2_busy_i,
  input  logic               ps2_tx_acked_i,
  input  logic               ps2_tx_errd_i,
  input  logic [7:0]         ps2_code_i,
  input  logic               ps2_code_v_i
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int TW    = $clog2(RESP_TIMEOUT_US + 1);
  localparam logic [TW-1:0]    TMO    = TW'(RESP_TIMEOUT_US);
  localparam logic [FIFO_AW:0] FULL_N = (FIFO_AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_TX, WAIT_RESP} state_t;

  state_t              state;
  logic [7:0]          mem [DEPTH];
  logic [FIFO_AW-1:0]  wr_ptr, rd_ptr;
  logic [FIFO_AW:0]    count;
  logic                push_req, push, pop, full;
  logic [7:0]          cmd_q;
  logic [TW-1:0]       timer;
  logic                timed_out, can_retry;

`ifdef PS2K_CMD_RETRY_EN
  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [RW-1:0] MAXR = RW'(MAX_RETRY);
  logic [RW-1:0] attempt;
`endif

  // The response byte is owned by the command sequencer while waiting for it.
  always_comb begin
    push_req  = ps2_code_v_i && (state != WAIT_RESP);
    pop       = kbd_deq_i && (count != '0);
    full      = (count == FULL_N);
    push      = push_req && (!full || pop);
    timed_out = (timer == TMO);
`ifdef PS2K_CMD_RETRY_EN
    can_retry = (attempt < MAXR);
`else
    can_retry = 1'b0;
`endif
    kbd_head_o = (count == '0) ? 8'h00 : mem[rd_ptr];
  end

  assign kbd_count_o = count;

  always_ff @(posedge clk6x) begin
    if (push) mem[wr_ptr] <= ps2_code_i;
  end

  always_ff @(posedge clk6x) begin
    if (!resetn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      kbd_ovf_o <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push_req && full && !pop)
        kbd_ovf_o <= 1'b1;
      else if (pop && !push && count == (FIFO_AW+1)'(1))
        kbd_ovf_o <= 1'b0;
    end
  end

  // An idle port at request time lets IDLE issue the first send directly.
  always_ff @(posedge clk6x) begin
    if (!resetn) begin
      state       <= IDLE;
      cmd_q       <= '0;
      status_o    <= '0;
      ps2_cmd_o   <= '0;
      ps2_cmd_v_o <= 1'b0;
      cmd_busy_o  <= 1'b0;
      timer       <= '0;
`ifdef PS2K_CMD_RETRY_EN
      attempt     <= '0;
`endif
    end else begin
      ps2_cmd_v_o <= 1'b0;
      if ((state == WAIT_TX || state == WAIT_RESP) && ck1us && !timed_out)
        timer <= timer + 1'b1;
      case (state)
        IDLE: begin
          if (cmd_v_i) begin
            cmd_q      <= cmd_i;
            status_o   <= 8'h00;
            cmd_busy_o <= 1'b1;
`ifdef PS2K_CMD_RETRY_EN
            attempt    <= '0;
`endif
            if (!ps2_busy_i) begin
              ps2_cmd_o   <= cmd_i;
              ps2_cmd_v_o <= 1'b1;
              timer       <= '0;
              state       <= WAIT_TX;
            end else begin
              state <= SEND;
            end
          end
        end
        SEND: begin
          if (!ps2_busy_i) begin
            ps2_cmd_o   <= cmd_q;
            ps2_cmd_v_o <= 1'b1;
            timer       <= '0;
            state       <= WAIT_TX;
          end
        end
        WAIT_TX: begin
          if (ps2_tx_acked_i) begin
            timer <= '0;
            state <= WAIT_RESP;
          end else if (ps2_tx_errd_i && can_retry) begin
`ifdef PS2K_CMD_RETRY_EN
            attempt <= attempt + 1'b1;
`endif
            state <= SEND;
          end else if (ps2_tx_errd_i || timed_out) begin
            status_o   <= 8'hFF;
            cmd_busy_o <= 1'b0;
            state      <= IDLE;
          end
        end
        WAIT_RESP: begin
          if (ps2_code_v_i) begin
            if (ps2_code_i == 8'hFE && can_retry) begin
`ifdef PS2K_CMD_RETRY_EN
              attempt <= attempt + 1'b1;
`endif
              state <= SEND;
            end else begin
              status_o   <= ps2_code_i;
              cmd_busy_o <= 1'b0;
              state      <= IDLE;
            end
          end else if (timed_out) begin
            status_o   <= 8'hFD;
            cmd_busy_o <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Directed self-checking bench for ps2_kbd_ctrl (FIFO, command sequencing, timeout, reset abort).
module tb_ps2_kbd_ctrl;

  logic       clk6x = 1'b0;
  logic       resetn = 1'b0;
  logic       ck1us = 1'b0;
  logic [7:0] kbd_head_o;
  logic       kbd_deq_i = 1'b0;
  logic [4:0] kbd_count_o;
  logic       kbd_ovf_o;
  logic [7:0] cmd_i = '0;
  logic       cmd_v_i = 1'b0;
  logic       cmd_busy_o;
  logic [7:0] status_o;
  logic [7:0] ps2_cmd_o;
  logic       ps2_cmd_v_o;
  logic       ps2_busy_i = 1'b0;
  logic       ps2_tx_acked_i = 1'b0;
  logic       ps2_tx_errd_i = 1'b0;
  logic [7:0] ps2_code_i = '0;
  logic       ps2_code_v_i = 1'b0;

  int n_vec = 0;
  int n_err = 0;
  int pulses = 0;
  logic [7:0] last_cmd = '0;
  int div = 0;

  ps2_kbd_ctrl #(.FIFO_AW(4), .RESP_TIMEOUT_US(50), .MAX_RETRY(3)) dut (
    .clk6x(clk6x), .resetn(resetn), .ck1us(ck1us),
    .kbd_head_o(kbd_head_o), .kbd_deq_i(kbd_deq_i), .kbd_count_o(kbd_count_o),
    .kbd_ovf_o(kbd_ovf_o), .cmd_i(cmd_i), .cmd_v_i(cmd_v_i), .cmd_busy_o(cmd_busy_o),
    .status_o(status_o), .ps2_cmd_o(ps2_cmd_o), .ps2_cmd_v_o(ps2_cmd_v_o),
    .ps2_busy_i(ps2_busy_i), .ps2_tx_acked_i(ps2_tx_acked_i), .ps2_tx_errd_i(ps2_tx_errd_i),
    .ps2_code_i(ps2_code_i), .ps2_code_v_i(ps2_code_v_i)
  );

  always #5 clk6x = ~clk6x;

  // One ck1us pulse every fifth clock.
  always begin
    @(posedge clk6x);
    #1;
    div   = (div == 4) ? 0 : div + 1;
    ck1us = (div == 4);
  end

  always @(negedge clk6x) begin
    if (ps2_cmd_v_o) begin
      pulses   = pulses + 1;
      last_cmd = ps2_cmd_o;
    end
  end

  task automatic tick();
    @(posedge clk6x);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    ps2_code_i = b; ps2_code_v_i = 1'b1;
    tick();
    ps2_code_v_i = 1'b0;
  endtask

  task automatic pop();
    kbd_deq_i = 1'b1;
    tick();
    kbd_deq_i = 1'b0;
  endtask

  task automatic send_cmd(input logic [7:0] c);
    cmd_i = c; cmd_v_i = 1'b1;
    tick();
    cmd_v_i = 1'b0;
  endtask

  task automatic ack();
    ps2_tx_acked_i = 1'b1;
    tick();
    ps2_tx_acked_i = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) tick();
    n_vec += 7;
    if (kbd_head_o !== 8'h00) begin n_err++; $display("FAIL rst_head got %h want 00", kbd_head_o); end
    if (kbd_count_o !== 5'd0) begin n_err++; $display("FAIL rst_count got %0d want 0", kbd_count_o); end
    if (kbd_ovf_o !== 1'b0) begin n_err++; $display("FAIL rst_ovf got %b want 0", kbd_ovf_o); end
    if (cmd_busy_o !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b want 0", cmd_busy_o); end
    if (status_o !== 8'h00) begin n_err++; $display("FAIL rst_status got %h want 00", status_o); end
    if (ps2_cmd_o !== 8'h00) begin n_err++; $display("FAIL rst_cmd got %h want 00", ps2_cmd_o); end
    if (ps2_cmd_v_o !== 1'b0) begin n_err++; $display("FAIL rst_cmd_v got %b want 0", ps2_cmd_v_o); end
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_scan_codes();
    logic [7:0] exp_h [4];
    exp_h[0] = 8'h1C; exp_h[1] = 8'hF0; exp_h[2] = 8'h1C; exp_h[3] = 8'h00;
    push(8'h1C); push(8'hF0); push(8'h1C);
    for (int i = 0; i < 4; i++) begin
      n_vec += 2;
      if (kbd_head_o !== exp_h[i]) begin n_err++; $display("FAIL scan_head[%0d] got %h want %h", i, kbd_head_o, exp_h[i]); end
      if (kbd_count_o !== 5'(3 - i)) begin n_err++; $display("FAIL scan_count[%0d] got %0d want %0d", i, kbd_count_o, 3 - i); end
      if (i < 3) pop();
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 17; i++) push(8'h20 + 8'(i));
    n_vec += 3;
    if (kbd_count_o !== 5'd16) begin n_err++; $display("FAIL ovf_count got %0d want 16", kbd_count_o); end
    if (kbd_ovf_o !== 1'b1) begin n_err++; $display("FAIL ovf_flag got %b want 1", kbd_ovf_o); end
    if (kbd_head_o !== 8'h20) begin n_err++; $display("FAIL ovf_head got %h want 20", kbd_head_o); end
    for (int i = 0; i < 16; i++) begin
      n_vec++;
      if (kbd_head_o !== 8'h20 + 8'(i)) begin n_err++; $display("FAIL ovf_order[%0d] got %h want %h", i, kbd_head_o, 8'h20 + 8'(i)); end
      if (i == 15) begin
        n_vec++;
        if (kbd_ovf_o !== 1'b1) begin n_err++; $display("FAIL ovf_before_last got %b want 1", kbd_ovf_o); end
      end
      pop();
    end
    n_vec += 3;
    if (kbd_ovf_o !== 1'b0) begin n_err++; $display("FAIL ovf_clear got %b want 0", kbd_ovf_o); end
    if (kbd_count_o !== 5'd0) begin n_err++; $display("FAIL ovf_drained got %0d want 0", kbd_count_o); end
    if (kbd_head_o !== 8'h00) begin n_err++; $display("FAIL ovf_empty_head got %h want 00", kbd_head_o); end
    for (int i = 0; i < 16; i++) push(8'h40 + 8'(i));
    ps2_code_i = 8'h99; ps2_code_v_i = 1'b1; kbd_deq_i = 1'b1;
    tick();
    ps2_code_v_i = 1'b0; kbd_deq_i = 1'b0;
    n_vec += 3;
    if (kbd_count_o !== 5'd16) begin n_err++; $display("FAIL full_pp_count got %0d want 16", kbd_count_o); end
    if (kbd_ovf_o !== 1'b0) begin n_err++; $display("FAIL full_pp_ovf got %b want 0", kbd_ovf_o); end
    if (kbd_head_o !== 8'h41) begin n_err++; $display("FAIL full_pp_head got %h want 41", kbd_head_o); end
    repeat (15) pop();
    n_vec++;
    if (kbd_head_o !== 8'h99) begin n_err++; $display("FAIL full_pp_tail got %h want 99", kbd_head_o); end
    pop();
  endtask

  task automatic test_cmd_ack();
    pulses = 0;
    send_cmd(8'hED);
    n_vec += 3;
    if (cmd_busy_o !== 1'b1) begin n_err++; $display("FAIL ack_busy got %b want 1", cmd_busy_o); end
    if (ps2_cmd_v_o !== 1'b1) begin n_err++; $display("FAIL ack_send_v got %b want 1", ps2_cmd_v_o); end
    if (ps2_cmd_o !== 8'hED) begin n_err++; $display("FAIL ack_send_byte got %h want ED", ps2_cmd_o); end
    tick();
    ack();
    push(8'hFA);
    n_vec += 4;
    if (status_o !== 8'hFA) begin n_err++; $display("FAIL ack_status got %h want FA", status_o); end
    if (cmd_busy_o !== 1'b0) begin n_err++; $display("FAIL ack_busy_fall got %b want 0", cmd_busy_o); end
    if (kbd_count_o !== 5'd0) begin n_err++; $display("FAIL ack_fifo got %0d want 0", kbd_count_o); end
    if (pulses !== 1 || last_cmd !== 8'hED) begin n_err++; $display("FAIL ack_pulses got %0d/%h want 1/ED", pulses, last_cmd); end
  endtask

  task automatic test_resend();
    int exp_p;
    bit seen;
`ifdef PS2K_CMD_RETRY_EN
    exp_p = 4;
`else
    exp_p = 1;
`endif
    pulses = 0;
    send_cmd(8'hF3);
    for (int k = 0; k < 6; k++) begin
      seen = 1'b0;
      for (int c = 0; c < 20; c++) begin
        if (ps2_cmd_v_o || !cmd_busy_o) begin seen = 1'b1; break; end
        tick();
      end
      if (!cmd_busy_o) break;
      if (!seen) begin n_vec++; n_err++; $display("FAIL resend_wait got no pulse want pulse"); break; end
      tick();
      ack();
      push(8'hFE);
    end
    n_vec += 3;
    if (pulses !== exp_p) begin n_err++; $display("FAIL resend_pulses got %0d want %0d", pulses, exp_p); end
    if (status_o !== 8'hFE) begin n_err++; $display("FAIL resend_status got %h want FE", status_o); end
    if (kbd_count_o !== 5'd0) begin n_err++; $display("FAIL resend_fifo got %0d want 0", kbd_count_o); end
  endtask

  task automatic test_timeout();
    int n_us;
    bit done;
    send_cmd(8'hF4);
    tick();
    ack();
    n_us = 0; done = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (ck1us) n_us++;
      tick();
      if (!cmd_busy_o) begin done = 1'b1; break; end
    end
    n_vec += 3;
    if (!done) begin n_err++; $display("FAIL tmo_finish got busy want idle"); end
    if (status_o !== 8'hFD) begin n_err++; $display("FAIL tmo_status got %h want FD", status_o); end
    if (n_us !== 50) begin n_err++; $display("FAIL tmo_us got %0d want 50", n_us); end
    push(8'h5A);
    n_vec += 2;
    if (kbd_count_o !== 5'd1) begin n_err++; $display("FAIL tmo_fifo_count got %0d want 1", kbd_count_o); end
    if (kbd_head_o !== 8'h5A) begin n_err++; $display("FAIL tmo_fifo_head got %h want 5A", kbd_head_o); end
    pop();
  endtask

  task automatic test_busy_reset();
    pulses = 0;
    ps2_busy_i = 1'b1;
    send_cmd(8'hF5);
    repeat (5) tick();
    n_vec += 2;
    if (pulses !== 0) begin n_err++; $display("FAIL defer_pulses got %0d want 0", pulses); end
    if (cmd_busy_o !== 1'b1) begin n_err++; $display("FAIL defer_busy got %b want 1", cmd_busy_o); end
    ps2_busy_i = 1'b0;
    tick();
    n_vec += 2;
    if (ps2_cmd_v_o !== 1'b1) begin n_err++; $display("FAIL defer_send got %b want 1", ps2_cmd_v_o); end
    if (ps2_cmd_o !== 8'hF5) begin n_err++; $display("FAIL defer_byte got %h want F5", ps2_cmd_o); end
    tick();
    resetn = 1'b0;
    repeat (2) tick();
    n_vec += 3;
    if (cmd_busy_o !== 1'b0) begin n_err++; $display("FAIL abort_busy got %b want 0", cmd_busy_o); end
    if (status_o !== 8'h00) begin n_err++; $display("FAIL abort_status got %h want 00", status_o); end
    if (ps2_cmd_o !== 8'h00) begin n_err++; $display("FAIL abort_cmd got %h want 00", ps2_cmd_o); end
    resetn = 1'b1;
    ps2_tx_acked_i = 1'b1;
    repeat (10) tick();
    ps2_tx_acked_i = 1'b0;
    n_vec += 2;
    if (pulses !== 1) begin n_err++; $display("FAIL abort_pulses got %0d want 1", pulses); end
    if (cmd_busy_o !== 1'b0) begin n_err++; $display("FAIL abort_idle got %b want 0", cmd_busy_o); end
  endtask

  initial begin
    test_reset();
    test_scan_codes();
    test_overflow();
    test_cmd_ack();
    test_resend();
    test_timeout();
    test_busy_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
